// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single-port data memory between the pipeline MA stage (the default
//   owner) and an external loader/debug port.
//
//   The loader is granted bursts of beats. If the MA stage is busy, the loader waits,
//   but only up to STARVE_MAX cycles before it is forced in.
//
//   While the loader owns the memory, pipe_stall freezes the pipeline. MA reads are
//   combinational. Loader reads come back one cycle later on ext_rvalid/ext_rdata.
//
//   Handshake: ext_req is held (with stable ext_* fields) until a cycle in which
//   ext_gnt is high. That cycle is the accepted beat: a write lands at its closing
//   clock edge, and a read returns data in the following cycle.
//
//   Optional feature: define ARB_PERF_CNT_EN to add the stall_cnt output. stall_cnt
//   is a saturating count of the cycles in which pipe_stall was high.
//
//   state_dbg exposes the arbiter state (0 = S_PIPE, 1 = S_EXT).
module dmem_port_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int STARVE_MAX = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_req,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic [DATA_W-1:0] pipe_rdata,
    output logic              pipe_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic              ext_last,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              state_dbg
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [BW-1:0] BURST_TOP  = BW'(BURST_MAX - 1);

    typedef enum logic {S_PIPE = 1'b0, S_EXT = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
    logic              ext_rvalid_q, ext_rvalid_d;
    logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
    logic              mem_we_c, ext_gnt_c, pipe_stall_c;

    // Next state, counters and the memory mux for the current owner.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        mem_addr     = pipe_addr;
        mem_wdata    = pipe_wdata;
        mem_we_c     = 1'b0;
        ext_gnt_c    = 1'b0;
        pipe_stall_c = 1'b0;
        case (state_q)
            S_PIPE: begin
                mem_we_c = pipe_req & pipe_we;
                if (!ext_req) begin
                    starve_cnt_d = '0;
                end else if (pipe_req && (starve_cnt_q != STARVE_TOP)) begin
                    starve_cnt_d = starve_cnt_q + SW'(1);
                end
                // A busy MA keeps the port until the loader has waited long enough.
                if (ext_req && (!pipe_req || (starve_cnt_q == STARVE_TOP))) begin
                    state_d      = S_EXT;
                    starve_cnt_d = '0;
                    burst_cnt_d  = '0;
                end
            end
            S_EXT: begin
                mem_addr     = ext_addr;
                mem_wdata    = ext_wdata;
                ext_gnt_c    = ext_req;
                mem_we_c     = ext_req & ext_we;
                pipe_stall_c = pipe_req;
                starve_cnt_d = '0;
                if (!ext_req) begin
                    state_d = S_PIPE;
                end else begin
                    // Saturate so a long idle-MA burst still yields on the next beat
                    // once MA starts asking.
                    if (burst_cnt_q != BURST_TOP) begin
                        burst_cnt_d = burst_cnt_q + BW'(1);
                    end
                    if (ext_last || ((burst_cnt_q == BURST_TOP) && pipe_req)) begin
                        state_d = S_PIPE;
                    end
                end
            end
            default: state_d = S_PIPE;
        endcase
    end

    // Loader read return: capture on a granted read beat, otherwise hold.
    always_comb begin
        ext_rvalid_d = ext_gnt_c & ~ext_we;
        ext_rdata_d  = ext_rdata_q;
        if (ext_gnt_c && !ext_we) begin
            ext_rdata_d = mem_rdata;
        end
    end

    // State and counter registers; reset aborts any burst immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_PIPE;
            starve_cnt_q <= '0;
            burst_cnt_q  <= '0;
            ext_rvalid_q <= 1'b0;
            ext_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            ext_rvalid_q <= ext_rvalid_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

    // Outputs are held inactive while reset is high so no in-flight write lands.
    assign mem_we     = mem_we_c & ~reset;
    assign ext_gnt    = ext_gnt_c & ~reset;
    assign pipe_stall = pipe_stall_c & ~reset;
    assign pipe_rdata = mem_rdata;
    assign ext_rvalid = ext_rvalid_q;
    assign ext_rdata  = ext_rdata_q;
    assign state_dbg  = (state_q == S_EXT);

`ifdef ARB_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of cycles in which MA was locked out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (pipe_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed testbench for dmem_port_arbiter, with a behavioural data memory
// (async read, sync write).
module tb_dmem_port_arbiter;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              pipe_req, pipe_we, ext_req, ext_we, ext_last;
    logic [ADDR_W-1:0] pipe_addr, ext_addr;
    logic [DATA_W-1:0] pipe_wdata, ext_wdata;
    logic [DATA_W-1:0] pipe_rdata, ext_rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              pipe_stall, ext_gnt, ext_rvalid, mem_we, state_dbg;
`ifdef ARB_PERF_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    logic [DATA_W-1:0] mem [0:255];
    logic              pl_we = 1'b0;
    logic [7:0]        pl_addr = 8'h00;
    logic [DATA_W-1:0] pl_data = '0;

    int checks = 0;
    int passed = 0;

    dmem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .STARVE_MAX(8), .BURST_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr),
        .pipe_wdata(pipe_wdata), .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_last(ext_last), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
        .ext_rdata(ext_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .state_dbg(state_dbg)
`ifdef ARB_PERF_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // Clock.
    always #5 clk = ~clk;

    // Data memory: async read, sync write, plus a preload path for test setup.
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end

    task automatic idle;
        pipe_req = 0; pipe_we = 0; pipe_addr = '0; pipe_wdata = '0;
        ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0; ext_last = 0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [DATA_W-1:0] d);
        pl_addr = a; pl_data = d; pl_we = 1'b1;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic test_reset;
        idle();
        pipe_req = 1; pipe_we = 1; pipe_addr = 16'h0005; pipe_wdata = 16'h7777;
        ext_req = 1; ext_we = 1;
        #1 reset = 1'b1;
        @(negedge clk);
        checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else passed++;
        checks++; if (pipe_stall !== 1'b0) $display("FAIL reset_pipe_stall: got %b want 0", pipe_stall); else passed++;
        checks++; if (ext_gnt !== 1'b0) $display("FAIL reset_ext_gnt: got %b want 0", ext_gnt); else passed++;
        checks++; if (ext_rvalid !== 1'b0) $display("FAIL reset_ext_rvalid: got %b want 0", ext_rvalid); else passed++;
        checks++; if (ext_rdata !== 16'h0000) $display("FAIL reset_ext_rdata: got %h want 0000", ext_rdata); else passed++;
        checks++; if (state_dbg !== 1'b0) $display("FAIL reset_state: got %b want 0", state_dbg); else passed++;
        @(posedge clk); #1;
        idle();
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ext_read;
        preload(8'h10, 16'hBEEF);
        pipe_req = 0; pipe_addr = 16'h0011;
        ext_req = 1; ext_we = 0; ext_addr = 16'h0010; ext_last = 1;
        @(negedge clk);
        checks++; if (ext_gnt !== 1'b0) $display("FAIL rd_gnt_req_cycle: got %b want 0", ext_gnt); else passed++;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (ext_gnt !== 1'b1) $display("FAIL rd_gnt: got %b want 1", ext_gnt); else passed++;
        checks++; if (mem_addr !== 16'h0010) $display("FAIL rd_mem_addr: got %h want 0010", mem_addr); else passed++;
        checks++; if (pipe_stall !== 1'b0) $display("FAIL rd_pipe_stall: got %b want 0", pipe_stall); else passed++;
        @(posedge clk); #1;
        ext_req = 0;
        @(negedge clk);
        checks++; if (ext_rvalid !== 1'b1) $display("FAIL rd_rvalid: got %b want 1", ext_rvalid); else passed++;
        checks++; if (ext_rdata !== 16'hBEEF) $display("FAIL rd_rdata: got %h want beef", ext_rdata); else passed++;
        checks++; if (state_dbg !== 1'b0) $display("FAIL rd_back_to_pipe: got %b want 0", state_dbg); else passed++;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (ext_rvalid !== 1'b0) $display("FAIL rd_rvalid_drop: got %b want 0", ext_rvalid); else passed++;
        checks++; if (ext_rdata !== 16'hBEEF) $display("FAIL rd_rdata_hold: got %h want beef", ext_rdata); else passed++;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_reset_mid_burst;
        preload(8'h30, 16'h0000);
        pipe_addr = 16'h0007;
        ext_req = 1; ext_we = 1; ext_addr = 16'h0030; ext_wdata = 16'h5555; ext_last = 0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (ext_gnt !== 1'b1) $display("FAIL rmb_gnt: got %b want 1", ext_gnt); else passed++;
        checks++; if (mem_we !== 1'b1) $display("FAIL rmb_we_before: got %b want 1", mem_we); else passed++;
        #1 reset = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) $display("FAIL rmb_we_reset: got %b want 0", mem_we); else passed++;
        checks++; if (state_dbg !== 1'b0) $display("FAIL rmb_state: got %b want 0", state_dbg); else passed++;
        checks++; if (mem_addr !== 16'h0007) $display("FAIL rmb_mux: got %h want 0007", mem_addr); else passed++;
        @(posedge clk); #1;
        idle();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (mem[8'h30] !== 16'h0000) $display("FAIL rmb_no_write: got %h want 0000", mem[8'h30]); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_starvation;
        int first = -1;
        int stalls = 0;
        int bad = 0;
        pipe_req = 1; pipe_we = 0; pipe_addr = 16'h0001;
        ext_req = 1; ext_we = 0; ext_addr = 16'h0010; ext_last = 1;
        for (int c = 0; c < 30 && first < 0; c++) begin
            @(negedge clk);
            if (ext_gnt === 1'b1) first = c;
            if (pipe_stall !== ext_gnt) bad++;
            if (pipe_stall === 1'b1) stalls++;
            @(posedge clk); #1;
        end
        ext_req = 0;
        checks++; if (first != 9) $display("FAIL starve_first_gnt: got cycle %0d want 9", first); else passed++;
        checks++; if (bad != 0) $display("FAIL starve_stall_eq_gnt: got %0d mismatched cycles want 0", bad); else passed++;
        checks++; if (stalls != 1) $display("FAIL starve_stall_cycles: got %0d want 1", stalls); else passed++;
        @(negedge clk);
        checks++; if (pipe_stall !== 1'b0) $display("FAIL starve_release: got %b want 0", pipe_stall); else passed++;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_burst;
        int beat = 0;
        int cur_run = 0;
        int gap = 0;
        int ma_bad = 0;
        int addr_bad = 0;
        int got;
        int runs[$];
        int gaps[$];
        int exp_runs[3];
        logic prev_gnt = 1'b0;
        logic [DATA_W-1:0] exp_d;
        exp_runs = '{4, 4, 2};
        pipe_req = 1; pipe_we = 0; pipe_addr = 16'h0002;
        for (int c = 0; c < 200 && beat < 10; c++) begin
            ext_req = 1; ext_we = 1;
            ext_addr = 16'h0040 + 16'(beat);
            ext_wdata = 16'hA000 + 16'(beat);
            ext_last = (beat == 9);
            @(negedge clk);
            if (ext_gnt === 1'b1) begin
                if (!prev_gnt && runs.size() > 0) gaps.push_back(gap);
                if (mem_addr !== ext_addr || mem_we !== 1'b1) addr_bad++;
                cur_run++;
                gap = 0;
            end else begin
                if (prev_gnt) begin
                    runs.push_back(cur_run);
                    cur_run = 0;
                end
                if (pipe_stall !== 1'b0) ma_bad++;
                gap++;
            end
            prev_gnt = ext_gnt;
            @(posedge clk); #1;
            if (prev_gnt) beat++;
        end
        if (cur_run > 0) runs.push_back(cur_run);
        idle();
        checks++; if (runs.size() != 3) $display("FAIL burst_count: got %0d want 3", runs.size()); else passed++;
        for (int i = 0; i < 3; i++) begin
            got = (i < runs.size()) ? runs[i] : -1;
            checks++; if (got != exp_runs[i]) $display("FAIL burst_len%0d: got %0d want %0d", i, got, exp_runs[i]); else passed++;
        end
        for (int i = 0; i < 2; i++) begin
            got = (i < gaps.size()) ? gaps[i] : -1;
            checks++; if (got != 9) $display("FAIL burst_ma_gap%0d: got %0d want 9", i, got); else passed++;
        end
        checks++; if (ma_bad != 0) $display("FAIL burst_ma_served: got %0d stalled cycles want 0", ma_bad); else passed++;
        checks++; if (addr_bad != 0) $display("FAIL burst_beat_order: got %0d bad beats want 0", addr_bad); else passed++;
        for (int i = 0; i < 10; i++) begin
            exp_d = 16'hA000 + 16'(i);
            checks++; if (mem[8'h40 + 8'(i)] !== exp_d) $display("FAIL burst_mem%0d: got %h want %h", i, mem[8'h40 + 8'(i)], exp_d); else passed++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ma_priority;
        logic got = 1'b0;
        pipe_req = 1; pipe_we = 1; pipe_addr = 16'h0020; pipe_wdata = 16'h1234;
        ext_req = 1; ext_we = 0; ext_addr = 16'h0020; ext_last = 1;
        @(negedge clk);
        checks++; if (mem_we !== 1'b1) $display("FAIL prio_mem_we: got %b want 1", mem_we); else passed++;
        checks++; if (mem_addr !== 16'h0020) $display("FAIL prio_mem_addr: got %h want 0020", mem_addr); else passed++;
        checks++; if (mem_wdata !== 16'h1234) $display("FAIL prio_mem_wdata: got %h want 1234", mem_wdata); else passed++;
        checks++; if (ext_gnt !== 1'b0) $display("FAIL prio_ext_gnt: got %b want 0", ext_gnt); else passed++;
        @(posedge clk); #1;
        pipe_req = 0; pipe_we = 0;
        @(negedge clk);
        checks++; if (pipe_rdata !== 16'h1234) $display("FAIL prio_pipe_rdata: got %h want 1234", pipe_rdata); else passed++;
        @(posedge clk); #1;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (ext_gnt === 1'b1) got = 1'b1;
            @(posedge clk); #1;
        end
        ext_req = 0;
        checks++; if (got !== 1'b1) $display("FAIL prio_ext_gnt_later: got %b want 1", got); else passed++;
        @(negedge clk);
        checks++; if (ext_rvalid !== 1'b1) $display("FAIL prio_rvalid: got %b want 1", ext_rvalid); else passed++;
        checks++; if (ext_rdata !== 16'h1234) $display("FAIL prio_rdata: got %h want 1234", ext_rdata); else passed++;
        @(posedge clk); #1;
        idle();
    endtask

`ifdef ARB_PERF_CNT_EN
    task automatic test_perf_cnt;
        int grants = 0;
        int stalls = 0;
        logic [15:0] start = '0;
        pipe_req = 1; pipe_we = 0; pipe_addr = 16'h0003;
        ext_req = 1; ext_we = 0; ext_addr = 16'h0010; ext_last = 1;
        for (int c = 0; c < 100 && grants < 3; c++) begin
            @(negedge clk);
            if (c == 0) start = stall_cnt;
            if (pipe_stall === 1'b1) stalls++;
            if (ext_gnt === 1'b1) grants++;
            @(posedge clk); #1;
        end
        idle();
        checks++; if (grants != 3) $display("FAIL perf_grants: got %0d want 3", grants); else passed++;
        checks++; if (stalls != 3) $display("FAIL perf_stall_cycles: got %0d want 3", stalls); else passed++;
        checks++; if (int'(stall_cnt - start) != stalls) $display("FAIL perf_stall_cnt: got %0d want %0d", stall_cnt - start, stalls); else passed++;
        @(posedge clk); #1;
    endtask
`endif

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

    // Test sequence and final report.
    initial begin
        idle();
        test_reset();
        test_ext_read();
        test_reset_mid_burst();
        test_starvation();
        test_burst();
        test_ma_priority();
`ifdef ARB_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
